zx_key_serializer: RTL and testbench

//  Upstream driver for hidman_zx_bus's CH446Q-style serial keyboard port (DAT/SK/STB).

---
 rtl/zx_key_serializer.sv | 177 +++++++++++++++++
 tb/tb_zx_key_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zx_key_serializer.sv
// Serializer for a CH446Q-style keyboard port: buffers crosspoint commands and shifts
// each one out as AY[2:0],AX[3:0] MSB first on DAT/SK, then latches the state with STB.
module zx_key_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV        = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_y,
  input  logic [3:0] cmd_x,
  input  logic       cmd_state,
  output logic       busy,
  output logic       DAT,
  output logic       SK,
  output logic       STB
);

  // state  | meaning
  // IDLE   | waiting for a queued command
  // BIT_LO | SK low, DAT carries the current address bit
  // BIT_HI | SK high, receiver samples DAT
  // STB_SU | SK low, DAT switches to the switch state
  // STB_HI | STB high, receiver latches the state
  // GAP    | STB low, then next command or IDLE
  typedef enum logic [2:0] {IDLE, BIT_LO, BIT_HI, STB_SU, STB_HI, GAP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop;
  logic [7:0]    head;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    shreg_q, shreg_d;
  logic          st_q, st_d;
  logic          dat_q, dat_d;
  logic          sk_q, sk_d;
  logic          stb_q, stb_d;
  logic          ph_last;

  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {cmd_y, cmd_x, cmd_state};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign ph_last = (phase_q == PH_LAST);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    st_d    = st_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shreg_d = head[7:1];
          st_d    = head[0];
          idx_d   = 3'd6;
          phase_d = '0;
          state_d = BIT_LO;
        end
      end
      default: begin
        if (!ph_last) begin
          phase_d = phase_q + PW'(1);
        end else begin
          phase_d = '0;
          case (state_q)
            BIT_LO: state_d = BIT_HI;
            BIT_HI: begin
              if (idx_q == 3'd0) begin
                state_d = STB_SU;
              end else begin
                idx_d   = idx_q - 3'd1;
                state_d = BIT_LO;
              end
            end
            STB_SU: state_d = STB_HI;
            STB_HI: state_d = GAP;
            GAP: begin
              if (count_q != '0) begin
                pop     = 1'b1;
                shreg_d = head[7:1];
                st_d    = head[0];
                idx_d   = 3'd6;
                state_d = BIT_LO;
              end else begin
                state_d = IDLE;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  // Pins follow the current state one cycle later, so every pin comes straight from a flop.
  always_comb begin
    dat_d = dat_q;
    sk_d  = 1'b0;
    stb_d = 1'b0;
    case (state_q)
      BIT_LO: dat_d = shreg_q[idx_q];
      BIT_HI: begin
        dat_d = shreg_q[idx_q];
        sk_d  = 1'b1;
      end
      STB_SU: dat_d = st_q;
      STB_HI: begin
        dat_d = st_q;
        stb_d = 1'b1;
      end
      GAP:     dat_d = st_q;
      default: dat_d = dat_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      st_q    <= 1'b0;
      dat_q   <= 1'b0;
      sk_q    <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      st_q    <= st_d;
      dat_q   <= dat_d;
      sk_q    <= sk_d;
      stb_q   <= stb_d;
    end
  end

  assign DAT  = dat_q;
  assign SK   = sk_q;
  assign STB  = stb_q;
  assign busy = (count_q != '0) | (state_q != IDLE);

endmodule

// File: tb/tb_zx_key_serializer.sv
// Bench for zx_key_serializer: three instances (DIV 2, 1, 3), each with a protocol
// monitor that decodes SK/STB frames and checks them against a scoreboard of accepted commands.
module tb_zx_key_serializer;

  localparam int NI = 3;
  localparam int D0 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst, valid, ready, busy, dat, sk, stb, cst;
  logic [2:0]    cy [NI];
  logic [3:0]    cx [NI];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gen_mon
    localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    logic [7:0] sb [$];
    logic [6:0] bits = '0;
    int         nbits = 0;
    int         nframes = 0;
    logic [7:0] last_frame = '0;
    logic       sk_p = 1'b0, stb_p = 1'b0, dat_p = 1'b0;

    zx_key_serializer #(.FIFO_DEPTH(4), .DIV(D)) u_dut (
      .CLK(clk), .RST(rst[g]), .cmd_valid(valid[g]), .cmd_ready(ready[g]),
      .cmd_y(cy[g]), .cmd_x(cx[g]), .cmd_state(cst[g]), .busy(busy[g]),
      .DAT(dat[g]), .SK(sk[g]), .STB(stb[g])
    );

    always @(posedge clk)
      if (!rst[g] && valid[g] && ready[g]) sb.push_back({cy[g], cx[g], cst[g]});

    always @(negedge clk) begin
      if (rst[g]) begin
        sb.delete();
        nbits = 0;
        sk_p  = 1'b0;
        stb_p = 1'b0;
        dat_p = 1'b0;
      end else begin
        chk("sk_stb_overlap", int'(sk[g] & stb[g]), 0);
        if (sk[g] && !sk_p) begin
          chk("dat_setup_sk", int'(dat[g]), int'(dat_p));
          bits = {bits[5:0], dat[g]};
          nbits++;
        end else if (sk[g] && sk_p) begin
          chk("dat_hold_sk", int'(dat[g]), int'(dat_p));
        end
        if (stb[g] && !stb_p) begin
          chk("bit_count", nbits, 7);
          nframes++;
          last_frame = {bits, dat[g]};
          if (sb.size() == 0) chk("unexpected_frame", int'(last_frame), -1);
          else chk("frame", int'(last_frame), int'(sb.pop_front()));
          nbits = 0;
        end else if (stb[g] != stb_p) begin
          chk("dat_hold_stb_fall", int'(dat[g]), int'(dat_p));
        end else if (stb[g]) begin
          chk("dat_hold_stb", int'(dat[g]), int'(dat_p));
        end
        sk_p  = sk[g];
        stb_p = stb[g];
        dat_p = dat[g];
      end
    end
  end

  // Call just after a rising edge; returns having passed the accepting edge (+1).
  task automatic push(input int g, input logic [2:0] y, input logic [3:0] x, input logic s,
                      output int waited);
    logic r;
    cy[g] = y; cx[g] = x; cst[g] = s; valid[g] = 1'b1;
    waited = 0;
    forever begin
      r = ready[g];
      @(posedge clk);
      #1;
      waited++;
      if (r) break;
      if (waited > 3000) begin
        chk("push_timeout", waited, 0);
        break;
      end
    end
    valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (busy[g] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy[g]), 0);
  endtask

  task automatic rnd(input int g);
    int w;
    for (int i = 0; i < 100; i++) begin
      push(g, 3'($urandom_range(7, 0)), 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), w);
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
    end
    wait_idle(g);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  logic sk_a [64], stb_a [64], dat_a [64], busy_a [64];
  int   w, w6 [6], first_sk, rises, stb_first, stb_len, busy_fall, dat_stb, f0, t0, quiet;
  logic sk_prev;

  initial begin
    rst = '1; valid = '0; cst = '0;
    for (int i = 0; i < NI; i++) begin cy[i] = '0; cx[i] = '0; end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dat", int'(dat[0]), 0);
    chk("rst_sk", int'(sk[0]), 0);
    chk("rst_stb", int'(stb[0]), 0);
    chk("rst_ready", int'(ready[0]), 1);
    chk("rst_busy", int'(busy[0]), 0);
    @(posedge clk); #1;
    rst = '0;
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (sk[0] | stb[0] | dat[0] | busy[0]) quiet++;
    end
    chk("idle_quiet", quiet, 0);

    // single frame timing, DIV=2
    @(posedge clk); #1;
    push(0, 3'd1, 4'd1, 1'b0, w);
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      sk_a[c] = sk[0]; stb_a[c] = stb[0]; dat_a[c] = dat[0]; busy_a[c] = busy[0];
    end
    first_sk = -1; rises = 0; stb_first = -1; stb_len = 0; busy_fall = -1; dat_stb = -1;
    for (int c = 0; c < 44; c++) begin
      if (sk_a[c] && (c == 0 || !sk_a[c-1])) begin
        rises++;
        if (first_sk < 0) first_sk = c;
      end
      if (stb_a[c]) begin
        stb_len++;
        if (stb_first < 0) stb_first = c;
        dat_stb = int'(dat_a[c]);
      end
      if (!busy_a[c] && busy_fall < 0) busy_fall = c;
    end
    chk("t2_busy_early", int'(busy_a[0]), 1);
    chk("t2_first_sk", first_sk, 2 + D0);
    chk("t2_sk_rises", rises, 7);
    chk("t2_stb_start", stb_first, 2 + 15 * D0);
    chk("t2_stb_len", stb_len, D0);
    chk("t2_dat_at_stb", dat_stb, 0);
    chk("t2_busy_fall", busy_fall, 1 + 17 * D0);
    chk("t2_frame", int'(gen_mon[0].last_frame), int'(8'b0010_0010));

    // FIFO fill with valid held high
    @(posedge clk); #1;
    f0 = gen_mon[0].nframes;
    t0 = 0;
    for (int j = 0; j < 6; j++) begin
      push(0, 3'(j), 4'(j + 2), 1'(j), w6[j]);
      if (j == 0) t0 = cyc;
      valid[0] = 1'b1;
    end
    valid[0] = 1'b0;
    for (int j = 0; j < 5; j++) chk("t3_accept_wait", w6[j], 1);
    chk("t3_sixth_wait", w6[5], 17 * D0 - 2);
    wait_idle(0);
    chk("t3_busy_span", cyc - t0, 1 + 6 * 17 * D0);
    chk("t3_frames", gen_mon[0].nframes - f0, 6);
    chk("t3_sb_empty", gen_mon[0].sb.size(), 0);

    // special keys
    @(posedge clk); #1;
    push(0, 3'd5, 4'd8, 1'b1, w);
    wait_idle(0);
    chk("t4_magic", int'(gen_mon[0].last_frame), int'(8'b1011_0001));
    @(posedge clk); #1;
    push(0, 3'd6, 4'd8, 1'b0, w);
    wait_idle(0);
    chk("t4_reset_key", int'(gen_mon[0].last_frame), int'(8'b1101_0000));

    // async reset during BIT_HI of bit 3
    @(posedge clk); #1;
    push(0, 3'd2, 4'd9, 1'b1, w);
    push(0, 3'd4, 4'd5, 1'b0, w);
    f0 = gen_mon[0].nframes;
    rises = 0; sk_prev = 1'b0;
    for (int n = 0; n < 400 && rises < 4; n++) begin
      @(negedge clk);
      if (sk[0] && !sk_prev) rises++;
      sk_prev = sk[0];
    end
    chk("t5_reach_bit3", rises, 4);
    chk("t5_dat_before", int'(dat[0]), 1);
    #2 rst[0] = 1'b1;
    #1;
    chk("t5_sk_async", int'(sk[0]), 0);
    chk("t5_dat_async", int'(dat[0]), 0);
    chk("t5_stb_async", int'(stb[0]), 0);
    chk("t5_busy_async", int'(busy[0]), 0);
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_stb", gen_mon[0].nframes - f0, 0);
    chk("t5_queue_lost", int'(busy[0]), 0);
    push(0, 3'd7, 4'd12, 1'b1, w);
    wait_idle(0);
    chk("t5_clean_count", gen_mon[0].nframes - f0, 1);
    chk("t5_clean_frame", int'(gen_mon[0].last_frame), int'(8'b1111_1001));
    chk("t5_sb_empty", gen_mon[0].sb.size(), 0);

    // random traffic on DIV=1 and DIV=3
    @(posedge clk); #1;
    fork
      rnd(1);
      rnd(2);
    join
    chk("t6_frames_div1", gen_mon[1].nframes, 100);
    chk("t6_frames_div3", gen_mon[2].nframes, 100);
    chk("t6_sb_empty_div1", gen_mon[1].sb.size(), 0);
    chk("t6_sb_empty_div3", gen_mon[2].sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
